// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the game sequencer and its environment (sync unit,
// buttons, graphics generator). slave = sequencer side, master = environment.
interface flappy_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [1:0] btn;
    logic       hit;
    logic       pass;
    logic       frame_tick;
    logic       flap;
    logic       gra_still;
    logic       game_reset;
    logic       game_over;
    logic [1:0] lives;
    logic [7:0] score;
    logic [2:0] state;

    modport master (
        output pixel_x, pixel_y, btn, hit, pass,
        input  frame_tick, flap, gra_still, game_reset, game_over, lives, score, state
    );
    modport slave (
        input  pixel_x, pixel_y, btn, hit, pass,
        output frame_tick, flap, gra_still, game_reset, game_over, lives, score, state
    );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Flappy game sequencer: frame tick from the scan position, button
// conditioning, and the idle/play/pause/dying/over state machine with lives and BCD score.
module flappy_game_ctrl #(
    parameter int LIVES       = 3,
    parameter int DIE_FRAMES  = 30,
    parameter int OVER_FRAMES = 120,
    parameter int TICK_Y      = 481
) (
    input  logic    clk,
    input  logic    reset,
    flappy_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        DYING = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t     state;
    logic       scan_hit, scan_hit_d, frame_tick;
    logic [1:0] btn_s1, btn_s2, btn_d, rise;
    logic       flap, gra_still, game_reset, game_over;
    logic [1:0] lives;
    logic [7:0] score, timer;

    // The scan position holds for several clks; only its first clk yields a tick.
    assign scan_hit = (bus.pixel_y == 10'(TICK_Y)) && (bus.pixel_x == 10'd0);
    assign rise     = btn_s2 & ~btn_d;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s[3:0] != 4'd9) return {s[7:4], s[3:0] + 4'd1};
        if (s[7:4] != 4'd9) return {s[7:4] + 4'd1, 4'd0};
        return 8'h00;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_hit_d <= 1'b0;
            frame_tick <= 1'b0;
            btn_s1     <= 2'b00;
            btn_s2     <= 2'b00;
            btn_d      <= 2'b00;
        end else begin
            scan_hit_d <= scan_hit;
            frame_tick <= scan_hit & ~scan_hit_d;
            btn_s1     <= bus.btn;
            btn_s2     <= btn_s1;
            btn_d      <= btn_s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lives      <= 2'(LIVES);
            score      <= 8'h00;
            timer      <= 8'd0;
            flap       <= 1'b0;
            game_reset <= 1'b0;
            gra_still  <= 1'b1;
            game_over  <= 1'b0;
        end else begin
            game_reset <= 1'b0;
            flap       <= rise[0] && (state == PLAY);
            // Free-running tick count; entry into DYING/OVER reloads it below.
            if (frame_tick) timer <= timer + 8'd1;
            case (state)
                IDLE: if (rise[1]) begin
                    lives      <= 2'(LIVES);
                    score      <= 8'h00;
                    game_reset <= 1'b1;
                    gra_still  <= 1'b0;
                    state      <= PLAY;
                end
                PLAY: begin
                    if (bus.hit) begin
                        timer     <= 8'd0;
                        gra_still <= 1'b1;
                        state     <= DYING;
                    end else begin
                        if (rise[1]) begin
                            gra_still <= 1'b1;
                            state     <= PAUSE;
                        end
                        if (bus.pass) score <= bcd_inc(score);
                    end
                end
                PAUSE: if (rise[1]) begin
                    gra_still <= 1'b0;
                    state     <= PLAY;
                end
                DYING: if (frame_tick && timer == 8'(DIE_FRAMES - 1)) begin
                    lives <= lives - 2'd1;
                    if (lives == 2'd1) begin
                        timer     <= 8'd0;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        game_reset <= 1'b1;
                        gra_still  <= 1'b0;
                        state      <= PLAY;
                    end
                end
                OVER: if (frame_tick && timer == 8'(OVER_FRAMES - 1)) begin
                    game_over <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    gra_still <= 1'b1;
                    game_over <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.frame_tick = frame_tick;
    assign bus.flap       = flap;
    assign bus.gra_still  = gra_still;
    assign bus.game_reset = game_reset;
    assign bus.game_over  = game_over;
    assign bus.lives      = lives;
    assign bus.score      = score;
    assign bus.state      = state;
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: directed vector table and corner sequences plus
// random stimulus, all checked every clk against a game-level reference model.
module tb_flappy_game_ctrl;
    localparam int DIE_F  = 30;
    localparam int OVER_F = 120;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    flappy_if bus();

    flappy_game_ctrl #(.LIVES(3), .DIE_FRAMES(DIE_F), .OVER_FRAMES(OVER_F), .TICK_Y(481))
        dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_greset = 0, n_flap = 0;

    // Reference model: game mode, lives, decimal score, frame ticks since entry.
    int       m_mode, m_lives, m_score, m_ticks;
    bit       m_tick, m_flap, m_grst, m_last_scan;
    bit [1:0] h1, h2, h3;   // btn sampled 1, 2, 3 clks ago

    typedef struct {
        logic [1:0] btn;
        logic       hit;
        logic       pass;
        int         reps;
        int         e_state;
        int         e_score;
        int         e_flaps;
    } vec_t;
    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = 0; m_lives = 3; m_score = 0; m_ticks = 0;
        m_tick = 0; m_flap = 0; m_grst = 0; m_last_scan = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    task automatic model_step();
        bit ft, scan;
        bit [1:0] r;
        if (reset) begin
            model_reset();
            return;
        end
        ft = m_tick;
        r  = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = bus.btn;
        scan = (bus.pixel_y == 10'd481) && (bus.pixel_x == 10'd0);
        m_tick = scan && !m_last_scan;
        m_last_scan = scan;
        m_flap = r[0] && (m_mode == 1);
        m_grst = 0;
        case (m_mode)
            0: if (r[1]) begin m_lives = 3; m_score = 0; m_grst = 1; m_mode = 1; end
            1: if (bus.hit) begin
                   m_mode = 3; m_ticks = 0;
               end else begin
                   if (r[1]) m_mode = 2;
                   if (bus.pass) m_score = (m_score + 1) % 100;
               end
            2: if (r[1]) m_mode = 1;
            3: if (ft) begin
                   m_ticks++;
                   if (m_ticks == DIE_F) begin
                       m_lives--;
                       if (m_lives == 0) begin m_mode = 4; m_ticks = 0; end
                       else begin m_grst = 1; m_mode = 1; end
                   end
               end
            4: if (ft) begin
                   m_ticks++;
                   if (m_ticks == OVER_F) m_mode = 0;
               end
            default: ;
        endcase
    endtask

    function automatic logic [17:0] exp_vec();
        logic [7:0] bcd;
        bcd = 8'(((m_score / 10) << 4) | (m_score % 10));
        return {m_tick, m_flap, (m_mode != 1), m_grst, (m_mode == 4),
                2'(m_lives), bcd, 3'(m_mode)};
    endfunction

    function automatic logic [17:0] got_vec();
        return {bus.frame_tick, bus.flap, bus.gra_still, bus.game_reset, bus.game_over,
                bus.lives, bus.score, bus.state};
    endfunction

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            if (bus.game_reset) n_greset++;
            if (bus.flap) n_flap++;
            chk("model", 32'(got_vec()), 32'(exp_vec()));
        end
    endtask

    task automatic idle_in();
        bus.btn = 2'b00; bus.hit = 1'b0; bus.pass = 1'b0;
        bus.pixel_x = 10'd5; bus.pixel_y = 10'd0;
    endtask

    task automatic frame();
        bus.pixel_x = 10'd0; bus.pixel_y = 10'd481;
        cyc(4);
        bus.pixel_x = 10'd5; bus.pixel_y = 10'd0;
        cyc(2);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int f0, g0, first, nt, tx, ty, tk;
        vt[0] = '{2'b00, 1'b0, 1'b1, 10, 1, 8'h10, 0};
        vt[1] = '{2'b00, 1'b0, 1'b1, 95, 1, 8'h05, 0};
        vt[2] = '{2'b10, 1'b0, 1'b0,  1, 2, 8'h05, 0};
        vt[3] = '{2'b01, 1'b0, 1'b1,  3, 2, 8'h05, 0};
        vt[4] = '{2'b00, 1'b1, 1'b0,  1, 2, 8'h05, 0};
        vt[5] = '{2'b10, 1'b0, 1'b0,  1, 1, 8'h05, 0};
        vt[6] = '{2'b01, 1'b0, 1'b0,  2, 1, 8'h05, 2};
        vt[7] = '{2'b00, 1'b1, 1'b1,  1, 3, 8'h05, 0};

        idle_in();
        model_reset();
        cyc(2);
        chk("rst state", bus.state, 0);
        chk("rst lives", bus.lives, 3);
        chk("rst score", bus.score, 0);
        chk("rst still", bus.gra_still, 1);
        chk("rst outs", {bus.frame_tick, bus.flap, bus.game_reset, bus.game_over}, 0);
        reset = 1'b0;
        cyc(2);

        // One frame's worth of blanking rows at 4 clks per pixel.
        nt = 0; tx = -1; ty = -1; tk = -1;
        for (int y = 480; y <= 482; y++)
            for (int x = 0; x < 800; x++)
                for (int k = 0; k < 4; k++) begin
                    bus.pixel_x = 10'(x); bus.pixel_y = 10'(y);
                    cyc(1);
                    if (bus.frame_tick) begin nt++; tx = x; ty = y; tk = k; end
                end
        idle_in();
        chk("tick count", nt, 1);
        chk("tick pos", {tx[15:0], ty[15:0]}, {16'd0, 16'd481});
        chk("tick latency", tk, 0);

        // Start held for 20 clks: a single game_reset and no pause toggle.
        g0 = n_greset; first = -1;
        bus.btn = 2'b10;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            if (bus.game_reset && first < 0) first = i;
        end
        idle_in();
        cyc(3);
        chk("start pulses", n_greset - g0, 1);
        chk("start latency ok", (first >= 3 && first <= 4), 1);
        chk("start state", bus.state, 1);
        chk("start lives", bus.lives, 3);
        chk("start score", bus.score, 0);
        chk("start still", bus.gra_still, 0);

        for (int i = 0; i < 8; i++) begin
            f0 = n_flap;
            for (int r = 0; r < vt[i].reps; r++) begin
                bus.btn = vt[i].btn; bus.hit = vt[i].hit; bus.pass = vt[i].pass;
                cyc(1);
                idle_in();
                cyc(1);
            end
            cyc(3);
            chk($sformatf("vec%0d state", i), bus.state, vt[i].e_state);
            chk($sformatf("vec%0d score", i), bus.score, vt[i].e_score);
            chk($sformatf("vec%0d flaps", i), n_flap - f0, vt[i].e_flaps);
        end

        // Three deaths: two restarts, then game over and the timed return to idle.
        g0 = n_greset;
        repeat (DIE_F - 1) frame();
        chk("die hold", bus.state, 3);
        frame();
        chk("die1 state", bus.state, 1);
        chk("die1 lives", bus.lives, 2);
        chk("die1 greset", n_greset - g0, 1);
        bus.hit = 1'b1; cyc(1); idle_in(); cyc(2);
        chk("hit2 state", bus.state, 3);
        repeat (DIE_F) frame();
        chk("die2 lives", {bus.state, 2'b00, bus.lives}, {3'd1, 2'b00, 2'd1});
        bus.hit = 1'b1; cyc(1); idle_in(); cyc(2);
        repeat (DIE_F) frame();
        chk("over state", bus.state, 4);
        chk("over flag", bus.game_over, 1);
        chk("over lives", bus.lives, 0);
        chk("over greset", n_greset - g0, 2);
        bus.btn = 2'b10; cyc(1); idle_in(); cyc(4);
        chk("over btn ignored", bus.state, 4);
        repeat (OVER_F - 1) frame();
        chk("over hold", bus.state, 4);
        frame();
        chk("idle state", bus.state, 0);
        chk("idle shown", {bus.lives, bus.score, bus.game_over}, {2'd0, 8'h05, 1'b0});

        // Reset in the middle of a death with button pulses still in flight.
        bus.btn = 2'b10; cyc(1); idle_in(); cyc(4);
        for (int i = 0; i < 3; i++) begin bus.pass = 1'b1; cyc(1); idle_in(); cyc(1); end
        bus.hit = 1'b1; cyc(1); idle_in(); cyc(2);
        repeat (10) frame();
        chk("pre-rst", {bus.state, bus.score}, {3'd3, 8'h03});
        bus.btn = 2'b11; cyc(1);
        bus.btn = 2'b00;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async rst", 32'(got_vec()), 32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 3'd0}));
        cyc(2);
        reset = 1'b0;
        g0 = n_greset; f0 = n_flap;
        cyc(8);
        chk("post-rst greset", n_greset - g0, 0);
        chk("post-rst flap", n_flap - f0, 0);
        chk("post-rst state", bus.state, 0);

        for (int c = 0; c < 4000; c++) begin
            if (c % 8 < 4) begin
                bus.pixel_x = 10'd0; bus.pixel_y = 10'd481;
            end else begin
                bus.pixel_x = 10'($urandom_range(799));
                bus.pixel_y = 10'($urandom_range(524));
            end
            if ($urandom_range(5) == 0) bus.btn = bus.btn ^ (2'b01 << $urandom_range(1));
            bus.hit  = ($urandom_range(59) == 0);
            bus.pass = ($urandom_range(3) == 0);
            cyc(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
